// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Each stage resolves BLKS_PER_STG blocks and forwards only the operand bits it has not resolved yet.
module pipelined_csel_adder #(
   parameter int WIDTH        = 16,
   parameter int BLK_W        = 4,
   parameter int BLKS_PER_STG = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NUM_BLK = WIDTH / BLK_W;
   localparam int LATENCY = (NUM_BLK + BLKS_PER_STG - 1) / BLKS_PER_STG;

   logic w_stall;

   // A stalled output freezes the entire pipe, bubbles included.
   assign w_stall  = g_stg[LATENCY-1].r_v & ~out_ready;
   assign in_ready = ~w_stall;

   for (genvar gk = 0; gk < LATENCY; gk++) begin : g_stg
      localparam int FIRST  = gk * BLKS_PER_STG;
      localparam int N_HERE = (FIRST + BLKS_PER_STG <= NUM_BLK) ? BLKS_PER_STG : NUM_BLK - FIRST;
      localparam int LO     = FIRST * BLK_W;
      localparam int RES    = (FIRST + N_HERE) * BLK_W;

      logic             w_v_in;
      logic             w_c_in;
      logic [WIDTH-1:LO] w_a_in;
      logic [WIDTH-1:LO] w_b_in;
      logic [RES-1:0]   w_s_out;
      logic [N_HERE:0]  w_cy;

      logic             r_v;
      logic             r_c;
      logic [RES-1:0]   r_s;

      if (gk == 0) begin : g_head
         assign w_v_in = in_valid;
         assign w_c_in = sub | c_in;
         assign w_a_in = a;
         assign w_b_in = sub ? ~b : b;
      end else begin : g_body
         assign w_v_in          = g_stg[gk-1].r_v;
         assign w_c_in          = g_stg[gk-1].r_c;
         assign w_a_in          = g_stg[gk-1].g_fwd.r_a;
         assign w_b_in          = g_stg[gk-1].g_fwd.r_b;
         assign w_s_out[LO-1:0] = g_stg[gk-1].r_s;
      end

      assign w_cy[0] = w_c_in;

      for (genvar gi = 0; gi < N_HERE; gi++) begin : g_blk
         localparam int BASE = (FIRST + gi) * BLK_W;
         logic [BLK_W:0] w_s0;
         logic [BLK_W:0] w_s1;

         // Both candidate sums are formed in parallel; the incoming carry only drives the mux.
         assign w_s0 = {1'b0, w_a_in[BASE +: BLK_W]} + {1'b0, w_b_in[BASE +: BLK_W]};
         assign w_s1 = {1'b0, w_a_in[BASE +: BLK_W]} + {1'b0, w_b_in[BASE +: BLK_W]}
                     + {{BLK_W{1'b0}}, 1'b1};
         assign w_s_out[BASE +: BLK_W] = w_cy[gi] ? w_s1[BLK_W-1:0] : w_s0[BLK_W-1:0];
         assign w_cy[gi+1]             = w_cy[gi] ? w_s1[BLK_W]     : w_s0[BLK_W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (!w_stall) begin
            r_v <= w_v_in;
            r_c <= w_cy[N_HERE];
            r_s <= w_s_out;
         end
      end

      if (RES < WIDTH) begin : g_fwd
         logic [WIDTH-1:RES] r_a;
         logic [WIDTH-1:RES] r_b;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (!w_stall) begin
               r_a <= w_a_in[WIDTH-1:RES];
               r_b <= w_b_in[WIDTH-1:RES];
            end
         end
      end

      if (gk == LATENCY - 1) begin : g_flag
         logic w_c_msb;
         logic r_ovf;

         // Carry into the MSB recovered from the MSB sum bit and its operands.
         assign w_c_msb = w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_s_out[WIDTH-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (!w_stall) begin
               r_ovf <= w_c_msb ^ w_cy[N_HERE];
            end
         end
      end
   end

   assign out_valid = g_stg[LATENCY-1].r_v;
   assign sum       = g_stg[LATENCY-1].r_s;
   assign c_out     = g_stg[LATENCY-1].r_c;
   assign ovf       = g_stg[LATENCY-1].g_flag.r_ovf;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder: default 16/4/2 instance plus a 32/8/1 instance.
// Expected results come from signed/unsigned integer arithmetic on the applied operands.
module tb_pipelined_csel_adder;

   localparam int LAT16 = 2;
   localparam int LAT32 = 4;

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        o;
      int          adv;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0, or16;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ir16, ov16, co16, of16;
   logic [15:0] s16;

   logic        iv32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0, or32;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ir32, ov32, co32, of32;
   logic [31:0] s32;

   pipelined_csel_adder u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .c_in(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
      .c_out(co16), .ovf(of16)
   );

   pipelined_csel_adder #(.WIDTH(32), .BLK_W(8), .BLKS_PER_STG(1)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .c_in(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
      .c_out(co32), .ovf(of32)
   );

   int   n_vec = 0;
   int   n_err = 0;
   int   rdy_mode = 0;
   exp_t q16[$];
   exp_t q32[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input int adv);
      exp_t        e;
      logic [63:0] mask;
      logic [63:0] full;
      longint      sa, sb, sr, lim;
      mask = (64'd1 << w) - 64'd1;
      lim  = longint'(1) << (w - 1);
      sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      if (sub) begin
         e.s = (a - b) & mask;
         e.c = (a >= b);
         sr  = sa - sb;
      end else begin
         full = a + b + 64'(cin);
         e.s  = full & mask;
         e.c  = (full >> w) != 64'd0;
         sr   = sa + sb + longint'(cin);
      end
      e.o   = (sr >= lim) || (sr < -lim);
      e.adv = adv;
      return e;
   endfunction

   // Output-ready driver: 0 = always ready, 1 = held off, 2 = random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       begin or16 = 1'b1; or32 = 1'b1; end
         1:       begin or16 = 1'b0; or32 = 1'b0; end
         default: begin
            or16 = ($urandom_range(0, 3) != 0);
            or32 = ($urandom_range(0, 3) != 0);
         end
      endcase
   end

   // Monitor for the 16-bit instance; adv16 counts clock edges on which the pipe advanced.
   int          adv16 = 0;
   logic        p_stall16 = 1'b0;
   logic [17:0] p_out16 = '0;
   exp_t        e16;
   always @(negedge clk) begin
      if (!rst_n) begin
         q16.delete();
         p_stall16 = 1'b0;
      end else begin
         chk("in_ready16", 64'(ir16), 64'(!(ov16 && !or16)));
         if (p_stall16) begin
            chk("hold_valid16", 64'(ov16), 64'd1);
            chk("hold_data16", 64'({s16, co16, of16}), 64'(p_out16));
         end
         if (ov16 && or16) begin
            chk("nonempty16", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
               e16 = q16.pop_front();
               chk("sum16", 64'(s16), e16.s);
               chk("c_out16", 64'(co16), 64'(e16.c));
               chk("ovf16", 64'(of16), 64'(e16.o));
               chk("latency16", 64'(adv16), 64'(e16.adv + LAT16));
            end
         end
         if (iv16 && ir16) q16.push_back(model(16, 64'(a16), 64'(b16), cin16, sub16, adv16));
         p_stall16 = ov16 && !or16;
         p_out16   = {s16, co16, of16};
         if (!p_stall16) adv16++;
      end
   end

   int          adv32 = 0;
   logic        p_stall32 = 1'b0;
   logic [33:0] p_out32 = '0;
   exp_t        e32;
   always @(negedge clk) begin
      if (!rst_n) begin
         q32.delete();
         p_stall32 = 1'b0;
      end else begin
         chk("in_ready32", 64'(ir32), 64'(!(ov32 && !or32)));
         if (p_stall32) chk("hold_data32", 64'({s32, co32, of32}), 64'(p_out32));
         if (ov32 && or32) begin
            chk("nonempty32", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
               e32 = q32.pop_front();
               chk("sum32", 64'(s32), e32.s);
               chk("c_out32", 64'(co32), 64'(e32.c));
               chk("ovf32", 64'(of32), 64'(e32.o));
               chk("latency32", 64'(adv32), 64'(e32.adv + LAT32));
            end
         end
         if (iv32 && ir32) q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32, adv32));
         p_stall32 = ov32 && !or32;
         p_out32   = {s32, co32, of32};
         if (!p_stall32) adv32++;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      logic acc;
      int   t;
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         acc = ir16;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 50);
      chk("accept16", 64'(acc), 64'd1);
      iv16 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      logic acc;
      int   t;
      a32 = a; b32 = b; cin32 = cin; sub32 = sub; iv32 = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         acc = ir32;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 50);
      chk("accept32", 64'(acc), 64'd1);
      iv32 = 1'b0;
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drain(input int bound);
      int t;
      t = 0;
      while ((q16.size() != 0 || q32.size() != 0) && t < bound) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain16", 64'(q16.size()), 64'd0);
      chk("drain32", 64'(q32.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid16", 64'(ov16), 64'd0);
      chk("rst_sum16", 64'(s16), 64'd0);
      chk("rst_cout16", 64'(co16), 64'd0);
      chk("rst_ovf16", 64'(of16), 64'd0);
      chk("rst_valid32", 64'(ov32), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready16", 64'(ir16), 64'd1);
      chk("rel_in_ready32", 64'(ir32), 64'd1);
      @(posedge clk);
      #1;

      // Directed vectors, back-to-back where paired.
      send16(16'h0000, 16'h0000, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      send16(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      send16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send16(16'h0005, 16'h0007, 1'b1, 1'b1);
      drain(20);

      // Backpressure: hold out_ready low while four ops stream in.
      rdy_mode = 1;
      fork
         begin
            for (int i = 0; i < 4; i++) send16(pick16(), pick16(), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (4) @(negedge clk);
            chk("stall_in_ready16", 64'(ir16), 64'd0);
            chk("stall_valid16", 64'(ov16), 64'd1);
            repeat (3) @(posedge clk);
            rdy_mode = 0;
         end
      join
      drain(20);

      // Reset with two results in flight.
      send16(16'h1234, 16'h1111, 1'b0, 1'b0);
      send16(16'hABCD, 16'h0101, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid16", 64'(ov16), 64'd0);
      chk("async_rst_sum16", 64'(s16), 64'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send16(16'h8000, 16'h8000, 1'b0, 1'b0);
      send16(16'h8000, 16'h0001, 1'b0, 1'b1);
      drain(20);

      // Randomised 16-bit sweep with random backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send16(pick16(), pick16(), 1'($urandom), 1'($urandom));
      end
      rdy_mode = 0;
      drain(50);

      // 32-bit, four-stage configuration.
      send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drain(20);
      rdy_mode = 2;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
         send32($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      rdy_mode = 0;
      drain(50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
